// File: rtl/count_pkg.sv
// Shared types and constants for the cascaded down-counter and its 2-bit slices.
package count_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dcount2.sv
// 2-bit loadable down-count slice; a slice at zero that is enabled borrows to 3.
module dcount2
    import count_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SLICE_W-1:0] load_val,
    input  logic               en_in,
    output logic [SLICE_W-1:0] q,
    output logic               zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en_in) begin
            q <= q - SLICE_W'(1);
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/count_down_cascade.sv
// Loadable down-counter/timer built from 2-bit slices with one-shot and auto-reload modes.
module count_down_cascade
    import count_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam int NSL = WIDTH / SLICE_W;

    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] sl_val;
    logic [NSL-1:0]   zero;
    logic [NSL-1:0]   lower_zero;
    logic [NSL-1:0]   en_sl;
    logic             q_zero;
    logic             terminal;
    logic             sl_load;
    logic             tc_n;

    assign q_zero   = &zero;
    assign terminal = (state == RUN) && en && q_zero && !load;
    // An auto-reload terminal edge reuses the slices' parallel-load path.
    assign sl_load  = load || (terminal && auto_reload);
    assign sl_val   = load ? load_val : reload_reg;

    always_comb begin
        lower_zero[0] = 1'b1;
        for (int k = 1; k < NSL; k++) begin
            lower_zero[k] = lower_zero[k-1] & zero[k-1];
        end
    end

    for (genvar k = 0; k < NSL; k++) begin : g_slice
        assign en_sl[k] = en && (state == RUN) && !q_zero && lower_zero[k];

        dcount2 u_slice (
            .clk      (clk),
            .rst      (rst),
            .load     (sl_load),
            .load_val (sl_val[k*SLICE_W +: SLICE_W]),
            .en_in    (en_sl[k]),
            .q        (q[k*SLICE_W +: SLICE_W]),
            .zero     (zero[k])
        );
    end

    always_comb begin
        state_n = state;
        tc_n    = 1'b0;
        if (load) begin
            state_n = RUN;
        end else if (terminal) begin
            tc_n = 1'b1;
            if (!auto_reload) begin
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tc         <= 1'b0;
            reload_reg <= '0;
        end else begin
            state <= state_n;
            tc    <= tc_n;
            if (load) begin
                reload_reg <= load_val;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_count_down_cascade.sv
// Randomized and directed bench for count_down_cascade against an arithmetic timer model.
module tb_count_down_cascade;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] q;
    logic         tc, busy, done;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Model: mode 0 idle, 1 running, 2 finished.
    int m_q = 0, m_rl = 0, m_mode = 0;
    bit m_tc = 1'b0;

    count_down_cascade #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_q <= 0; m_rl <= 0; m_mode <= 0; m_tc <= 1'b0;
        end else begin
            m_tc <= 1'b0;
            if (load) begin
                m_q <= int'(load_val); m_rl <= int'(load_val); m_mode <= 1;
            end else if (m_mode == 1 && en) begin
                if (m_q > 0) begin
                    m_q <= m_q - 1;
                end else begin
                    m_tc <= 1'b1;
                    if (auto_reload) m_q <= m_rl;
                    else m_mode <= 2;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_q", 32'(q), 32'(m_q));
            chk("model_tc", 32'(tc), 32'(m_tc));
            chk("model_busy", 32'(busy), 32'(m_mode == 1));
            chk("model_done", 32'(done), 32'(m_mode == 2));
        end
    end

    task automatic cyc(input logic ld, input int lv, input logic e, input logic ar, input logic r);
        @(negedge clk);
        rst = r; load = ld; load_val = W'(lv); en = e; auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int eq, input bit etc, input bit ebusy, input bit edone);
        chk({nm, "_q"}, 32'(q), 32'(eq));
        chk({nm, "_tc"}, 32'(tc), 32'(etc));
        chk({nm, "_busy"}, 32'(busy), 32'(ebusy));
        chk({nm, "_done"}, 32'(done), 32'(edone));
    endtask

    initial begin
        // Reset overrides a held load.
        cyc(1'b1, 9, 1'b1, 1'b0, 1'b1);
        checking = 1'b1;
        chk_out("rst1", 0, 0, 0, 0);
        cyc(1'b1, 9, 1'b1, 1'b0, 1'b1);
        chk_out("rst2", 0, 0, 0, 0);
        cyc(1'b0, 9, 1'b1, 1'b0, 1'b0);
        chk_out("idle", 0, 0, 0, 0);

        // One-shot from 5.
        cyc(1'b1, 5, 1'b1, 1'b0, 1'b0);
        chk_out("os_load", 5, 0, 1, 0);
        for (int i = 4; i >= 0; i--) begin
            cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
            chk_out("os_cnt", i, 0, 1, 0);
        end
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_out("os_term", 0, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
            chk_out("os_hold", 0, 0, 0, 1);
        end

        // Auto-reload from 3: period of 4 enabled cycles.
        cyc(1'b1, 3, 1'b1, 1'b1, 1'b0);
        chk_out("ar_load", 3, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
            chk_out("ar_cnt", ((3 - i) % 4 + 4) % 4, (i % 4) == 0, 1, 0);
        end

        // Enable gating and multi-slice borrows.
        cyc(1'b1, 16, 1'b0, 1'b0, 1'b0);
        chk("gate_load", 32'(q), 16);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk("gate_a", 32'(q), 15);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0); chk("gate_b", 32'(q), 15);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk("gate_c", 32'(q), 14);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0); chk("gate_d", 32'(q), 14);
        cyc(1'b1, 4, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk("borrow4", 32'(q), 3);
        cyc(1'b1, 63, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk("dec63", 32'(q), 62);

        // Reload mid-count, then reset mid-count.
        cyc(1'b1, 10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("mid_q2", 32'(q), 2);
        cyc(1'b1, 10, 1'b1, 1'b0, 1'b0);
        chk_out("mid_reload", 10, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("mid_q7", 32'(q), 7);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
        chk_out("mid_rst", 0, 0, 0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_out("mid_after", 0, 0, 0, 0);

        // Zero load and restart from DONE.
        cyc(1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk_out("z_load", 0, 0, 1, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_out("z_term", 0, 1, 0, 1);
        cyc(1'b1, 2, 1'b1, 1'b0, 1'b0);
        chk_out("rs_load", 2, 0, 1, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk_out("rs_1", 1, 0, 1, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk_out("rs_0", 0, 0, 1, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); chk_out("rs_tc", 0, 1, 0, 1);

        // Random traffic checked by the model on every cycle.
        for (int i = 0; i < 2000; i++) begin
            logic ld, e, ar, r;
            int lv;
            ld = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            ar = $urandom_range(0, 1) == 1;
            r  = ($urandom_range(0, 199) == 0);
            lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
            cyc(ld, lv, e, ar, r);
        end

        @(negedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
